// File: rtl/control_step_ctrl.sv
`timescale 1ns/1ps
// control_step_ctrl
// Run/step sequencer for control_top. Turns a board push button and mode
// switches into the controlSuspend hold signal, so the datapath can be run
// freely, single-stepped or advanced in fixed-length bursts. A breakpoint on
// register writes halts execution, and a saturating counter tracks how many
// cycles control_top was allowed to advance.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   mode[1:0]      00 HOLD, 01 RUN, 10 STEP, 11 BURST
//   step_btn       raw asynchronous push button, active high
//   cnt_clr        synchronous clear of cycle_count
//   bkpt_en        breakpoint enable
//   bkpt_addr      breakpoint register address
//   write_addr     register write address observed from control_top
//   write_en       register write enable observed from control_top
//   controlSuspend 1 = control_top holds, 0 = control_top advances this cycle
//   cycle_count    saturating count of advancing cycles
//   halted         breakpoint hit, waiting for a button press
//   busy           sequencer is in RUN, STEP or BURST
module control_step_ctrl #(
  parameter int CNT_WIDTH       = 16,
  parameter int BURST_LEN       = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ADDR_WIDTH      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  step_btn,
  input  logic                  cnt_clr,
  input  logic                  bkpt_en,
  input  logic [ADDR_WIDTH-1:0] bkpt_addr,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic                  write_en,
  output logic                  controlSuspend,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic                  halted,
  output logic                  busy
);

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_BURST, S_HALT} state_t;
  typedef enum logic [1:0] {M_HOLD, M_RUN, M_STEP, M_BURST} mode_t;

  // ---------------------------------------------------------------------------
  // Button path: 2-FF synchronizer, stable-sample debounce, rising-edge pulse
  // ---------------------------------------------------------------------------
  logic          r_s1, r_s2;
  logic          r_db, r_db_d;
  logic [DW-1:0] r_db_cnt;
  logic          w_press;

  // NOTE: every clocked process uses non-blocking assignments so all
  // registers sample the pre-edge values; blocking here would collapse the
  // synchronizer chain into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_db     <= 1'b0;
      r_db_d   <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_s1   <= step_btn;
      r_s2   <= r_s1;
      r_db_d <= r_db;
      if (r_s2 == r_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        // This edge is the DEBOUNCE_CYCLES-th consecutive differing sample.
        r_db     <= ~r_db;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DW'(1);
      end
    end
  end

  assign w_press = r_db & ~r_db_d;

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_t        r_state, w_next;
  logic [BW-1:0] r_burst_cnt, w_burst_next;
  mode_t         w_mode;
  logic          w_bkpt_hit;

  assign w_mode     = mode_t'(mode);
  assign w_bkpt_hit = bkpt_en && write_en && (write_addr == bkpt_addr);

  // State register (burst length counter travels with the state)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_next;
      r_burst_cnt <= w_burst_next;
    end
  end

  // Next-state logic
  // NOTE: both outputs get a default before the case so that no path leaves
  // them unassigned, which would otherwise infer latches.
  always_comb begin
    w_next       = r_state;
    w_burst_next = r_burst_cnt;
    unique case (r_state)
      S_IDLE: begin
        // Presses in HOLD or RUN mode fall through and are ignored.
        if (w_mode == M_RUN) begin
          w_next = S_RUN;
        end else if (w_press && w_mode == M_STEP) begin
          w_next = S_STEP;
        end else if (w_press && w_mode == M_BURST) begin
          w_next       = S_BURST;
          w_burst_next = BW'(BURST_LEN);
        end
      end
      S_RUN: begin
        if (w_bkpt_hit)            w_next = S_HALT;
        else if (w_mode != M_RUN)  w_next = S_IDLE;
      end
      S_STEP: begin
        w_next = w_bkpt_hit ? S_HALT : S_IDLE;
      end
      S_BURST: begin
        w_burst_next = r_burst_cnt - BW'(1);
        // Breakpoint outranks both completion and a HOLD abort.
        if (w_bkpt_hit)
          w_next = S_HALT;
        else if (w_mode == M_HOLD || r_burst_cnt == BW'(1))
          w_next = S_IDLE;
      end
      S_HALT: begin
        // The releasing press is consumed here and does not also step.
        if (w_press) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode of the next state; registered below so every output is a
  // glitch-free flop that follows the state register cycle for cycle.
  logic w_suspend_next, w_halted_next;

  always_comb begin
    w_suspend_next = 1'b1;
    w_halted_next  = 1'b0;
    unique case (w_next)
      S_RUN, S_STEP, S_BURST: w_suspend_next = 1'b0;
      S_HALT:                 w_halted_next  = 1'b1;
      default:                ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      controlSuspend <= 1'b1;
      halted         <= 1'b0;
      busy           <= 1'b0;
    end else begin
      controlSuspend <= w_suspend_next;
      halted         <= w_halted_next;
      busy           <= ~w_suspend_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Advancing-cycle counter: clear wins over increment, saturates at all ones
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cycle_count <= '0;
    end else if (!controlSuspend && cycle_count != '1) begin
      cycle_count <= cycle_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_control_step_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for control_step_ctrl (CNT_WIDTH=4, BURST_LEN=8,
// DEBOUNCE_CYCLES=4). Inputs change 1 ns after a rising edge; outputs are
// checked at the same point, i.e. after the edge they were updated on.
module tb_control_step_ctrl;

  localparam int CW = 4;
  localparam int BL = 8;
  localparam int DB = 4;
  localparam int AW = 5;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic          step_btn;
  logic          cnt_clr;
  logic          bkpt_en;
  logic [AW-1:0] bkpt_addr;
  logic [AW-1:0] write_addr;
  logic          write_en;
  logic          controlSuspend;
  logic [CW-1:0] cycle_count;
  logic          halted;
  logic          busy;

  int checks = 0;
  int errors = 0;

  control_step_ctrl #(
    .CNT_WIDTH      (CW),
    .BURST_LEN      (BL),
    .DEBOUNCE_CYCLES(DB),
    .ADDR_WIDTH     (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mode          (mode),
    .step_btn      (step_btn),
    .cnt_clr       (cnt_clr),
    .bkpt_en       (bkpt_en),
    .bkpt_addr     (bkpt_addr),
    .write_addr    (write_addr),
    .write_en      (write_en),
    .controlSuspend(controlSuspend),
    .cycle_count   (cycle_count),
    .halted        (halted),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clear the counter from an idle, non-advancing state.
  task automatic clear_count();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2'b00; step_btn = 1'b0; cnt_clr = 1'b0;
    bkpt_en = 1'b0; bkpt_addr = '0; write_addr = '0; write_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({controlSuspend, halted, busy, cycle_count} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL reset_state: susp/halt/busy/cnt = %b/%b/%b/%0d, want 1/0/0/0",
               controlSuspend, halted, busy, cycle_count);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({controlSuspend, halted, busy, cycle_count} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: susp/halt/busy/cnt = %b/%b/%b/%0d, want 1/0/0/0",
                 i, controlSuspend, halted, busy, cycle_count);
      end
    end
  endtask

  // Button held from edge 0 is pressed at edge DB+2; only that edge steps.
  task automatic test_step();
    logic exp;
    mode = 2'b10;
    step_btn = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      tick();
      exp = (e == DB + 2) ? 1'b0 : 1'b1;
      checks++;
      if (controlSuspend !== exp) begin
        errors++;
        $display("FAIL step_timing edge %0d: suspend=%b want %b", e, controlSuspend, exp);
      end
    end
    checks++;
    if (cycle_count !== 4'd1) begin
      errors++;
      $display("FAIL step_count: cycle_count=%0d want 1", cycle_count);
    end
    step_btn = 1'b0;
    repeat (12) tick();
    // Glitches shorter than the debounce window must never step.
    for (int g = 0; g < 3; g++) begin
      step_btn = 1'b1;
      repeat (3) tick();
      step_btn = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick();
        checks++;
        if (controlSuspend !== 1'b1) begin
          errors++;
          $display("FAIL glitch_step glitch %0d cycle %0d: suspend=%b want 1", g, i, controlSuspend);
        end
      end
    end
    checks++;
    if (cycle_count !== 4'd1) begin
      errors++;
      $display("FAIL glitch_count: cycle_count=%0d want 1", cycle_count);
    end
  endtask

  // Press at edge 6 gives advancing edges 6..13; a second debounced press
  // lands at edge 14, inside the burst's final cycle, and must be dropped.
  task automatic test_burst();
    logic exp;
    mode = 2'b00;
    clear_count();
    mode = 2'b11;
    for (int e = 0; e <= 40; e++) begin
      step_btn = (e <= 3) || (e >= 8 && e <= 11);
      tick();
      exp = (e >= DB + 2 && e < DB + 2 + BL) ? 1'b0 : 1'b1;
      checks++;
      if (controlSuspend !== exp || busy !== ~exp) begin
        errors++;
        $display("FAIL burst_timing edge %0d: suspend=%b busy=%b want suspend %b",
                 e, controlSuspend, busy, exp);
      end
    end
    step_btn = 1'b0;
    checks++;
    if (cycle_count !== 4'(BL)) begin
      errors++;
      $display("FAIL burst_count: cycle_count=%0d want %0d", cycle_count, BL);
    end
  endtask

  task automatic test_breakpoint();
    mode = 2'b00;
    clear_count();
    bkpt_en = 1'b1; bkpt_addr = 5'd5; write_addr = 5'd5; write_en = 1'b0;
    mode = 2'b01;
    for (int e = 0; e <= 3; e++) begin
      tick();
      checks++;
      if (controlSuspend !== 1'b0 || halted !== 1'b0) begin
        errors++;
        $display("FAIL bkpt_run edge %0d: suspend=%b halted=%b want 0/0", e, controlSuspend, halted);
      end
      // A write to a different address must not trip the breakpoint.
      if (e == 1) begin write_en = 1'b1; write_addr = 5'd6; end
      if (e == 2) begin write_en = 1'b0; write_addr = 5'd5; end
      if (e == 3) write_en = 1'b1;
    end
    tick();
    write_en = 1'b0;
    checks++;
    if ({halted, controlSuspend, busy, cycle_count} !== {1'b1, 1'b1, 1'b0, 4'd4}) begin
      errors++;
      $display("FAIL bkpt_halt: halt/susp/busy/cnt = %b/%b/%b/%0d, want 1/1/0/4",
               halted, controlSuspend, busy, cycle_count);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (halted !== 1'b1 || controlSuspend !== 1'b1) begin
        errors++;
        $display("FAIL bkpt_stay cycle %0d: halted=%b suspend=%b want 1/1", i, halted, controlSuspend);
      end
    end
    mode = 2'b00;
    step_btn = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      tick();
      checks++;
      if (halted !== (e < DB + 2) || controlSuspend !== 1'b1) begin
        errors++;
        $display("FAIL bkpt_release edge %0d: halted=%b suspend=%b want %b/1",
                 e, halted, controlSuspend, (e < DB + 2));
      end
    end
    checks++;
    if (cycle_count !== 4'd4) begin
      errors++;
      $display("FAIL bkpt_count: cycle_count=%0d want 4", cycle_count);
    end
    step_btn = 1'b0;
    bkpt_en = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_saturation();
    mode = 2'b00;
    clear_count();
    mode = 2'b01;
    repeat (20) tick();
    checks++;
    if (cycle_count !== 4'(CNT_MAX)) begin
      errors++;
      $display("FAIL sat_count: cycle_count=%0d want %0d", cycle_count, CNT_MAX);
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if (cycle_count !== 4'd0 || controlSuspend !== 1'b0) begin
      errors++;
      $display("FAIL clr_beats_inc: cycle_count=%0d suspend=%b want 0/0", cycle_count, controlSuspend);
    end
    tick();
    checks++;
    if (cycle_count !== 4'd1) begin
      errors++;
      $display("FAIL clr_resume: cycle_count=%0d want 1", cycle_count);
    end
    mode = 2'b00;
    tick();
    tick();
    checks++;
    if (cycle_count !== 4'd2 || controlSuspend !== 1'b1) begin
      errors++;
      $display("FAIL run_stop: cycle_count=%0d suspend=%b want 2/1", cycle_count, controlSuspend);
    end
  endtask

  task automatic test_reset_mid_burst();
    mode = 2'b11;
    for (int e = 0; e <= DB + 4; e++) begin
      step_btn = (e <= 3);
      tick();
    end
    checks++;
    if (controlSuspend !== 1'b0) begin
      errors++;
      $display("FAIL midburst_active: suspend=%b want 0", controlSuspend);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({controlSuspend, halted, busy, cycle_count} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL midburst_reset: susp/halt/busy/cnt = %b/%b/%b/%0d, want 1/0/0/0",
               controlSuspend, halted, busy, cycle_count);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (controlSuspend !== 1'b1 || cycle_count !== 4'd0) begin
        errors++;
        $display("FAIL midburst_residual cycle %0d: suspend=%b cnt=%0d want 1/0",
                 i, controlSuspend, cycle_count);
      end
    end
  endtask

  // With the button idle and the breakpoint off, control_top advances in a
  // cycle exactly when mode read RUN at the edge opening that cycle, and the
  // counter adds one per advancing cycle, clamps at its maximum and clears
  // on request.
  task automatic test_random_run();
    int m;
    bit clr;
    bit exp_susp;
    int exp_cnt;
    exp_susp = 1'b1;
    exp_cnt  = 0;
    for (int i = 0; i < 300; i++) begin
      m          = int'($urandom_range(0, 3));
      clr        = ($urandom_range(0, 7) == 0);
      mode       = 2'(m);
      cnt_clr    = clr;
      write_en   = 1'($urandom_range(0, 1));
      write_addr = AW'($urandom_range(0, 31));
      if (clr)            exp_cnt = 0;
      else if (!exp_susp) exp_cnt = (exp_cnt == CNT_MAX) ? CNT_MAX : exp_cnt + 1;
      exp_susp = (m != 1);
      tick();
      checks++;
      if (controlSuspend !== exp_susp || busy !== !exp_susp || halted !== 1'b0 ||
          cycle_count !== 4'(exp_cnt)) begin
        errors++;
        $display("FAIL random_run cycle %0d: susp=%b busy=%b halt=%b cnt=%0d want %b/%b/0/%0d",
                 i, controlSuspend, busy, halted, cycle_count, exp_susp, !exp_susp, exp_cnt);
      end
    end
    cnt_clr  = 1'b0;
    write_en = 1'b0;
    mode     = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_step();
    test_burst();
    test_breakpoint();
    test_saturation();
    test_reset_mid_burst();
    test_random_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
